// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and defaults for the SRAM port arbiter
package cpu_mem_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  // The owner of next cycle's response is whoever was granted this cycle.
  function automatic owner_e owner_from_gnt(input logic inst_gnt, input logic data_gnt);
    if (data_gnt)      return OWN_DATA;
    else if (inst_gnt) return OWN_INST;
    else               return OWN_NONE;
  endfunction

endpackage

// File: rtl/sram_arb_priority.sv
// rtl/sram_arb_priority.sv - data-first grant logic with a fetch starvation bound
module sram_arb_priority
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cancel_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic inst_gnt_o,
  output logic data_gnt_o
);

  localparam int                  STREAK_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                inst_elig;
  logic                starved;

  // Grant selection: data wins unless fetch has waited through STARVE_MAX data grants.
  always_comb begin
    inst_elig  = inst_req_i & ~cancel_i;
    starved    = (streak_q == STREAK_SAT);
    inst_gnt_o = 1'b0;
    data_gnt_o = 1'b0;
    if (!reset_i) begin
      if (data_req_i && !(inst_elig && starved)) begin
        data_gnt_o = 1'b1;
      end else if (inst_elig) begin
        inst_gnt_o = 1'b1;
      end
    end
    streak_d = streak_q;
    if (inst_gnt_o || !inst_elig) begin
      streak_d = '0;
    end else if (data_gnt_o && !starved) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak of data grants taken while fetch was waiting.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port SRAM between fetch and memory stages
module sram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rdy,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [BE_W-1:0]   data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rdy,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [BE_W-1:0]   sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       stall_cnt
);

  owner_e      owner_q;
  owner_e      owner_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  sram_arb_priority #(
    .STARVE_MAX (STARVE_MAX)
  ) u_priority (
    .clk_i      (clk),
    .reset_i    (reset),
    .cancel_i   (cancel),
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .inst_gnt_o (inst_gnt),
    .data_gnt_o (data_gnt)
  );

  // SRAM drive from the granted requester, plus response steering from the owner register.
  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = data_gnt ? data_wen : '0;
    sram_wdata = data_gnt ? data_wdata : '0;
    if (data_gnt) begin
      sram_addr = data_addr;
    end else if (inst_gnt) begin
      sram_addr = inst_addr;
    end else begin
      sram_addr = '0;
    end
    // Reset gating covers the first reset cycle, before owner_q has been cleared.
    inst_rdy   = (owner_q == OWN_INST) & ~cancel & ~reset;
    data_rdy   = (owner_q == OWN_DATA) & ~reset;
    inst_rdata = inst_rdy ? sram_rdata : '0;
    data_rdata = data_rdy ? sram_rdata : '0;
    stall_cnt  = stall_cnt_q;
  end

  // Next-state for the response owner and the fetch stall counter.
  always_comb begin
    owner_d     = owner_from_gnt(inst_gnt, data_gnt);
    stall_cnt_d = stall_cnt_q;
    if (inst_req && !inst_gnt && !cancel) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Owner register and stall counter; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      stall_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cancel;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rdy;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rdy;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] stall_cnt;

  int n_checks;
  int n_pass;

  sram_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cancel     (cancel),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rdy   (inst_rdy),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rdy   (data_rdy),
    .data_rdata (data_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cancel     = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wen   = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    sram_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    idle_inputs();
    #1;

    // 1: reset held three cycles with both requests high
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    data_req  = 1'b1;
    data_addr = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_inst_gnt", {31'b0, inst_gnt}, 32'd0);
      check("rst_data_gnt", {31'b0, data_gnt}, 32'd0);
      check("rst_sram_en",  {31'b0, sram_en},  32'd0);
      check("rst_rdy",      {30'b0, inst_rdy, data_rdy}, 32'd0);
      check("rst_sram_addr", sram_addr, 32'd0);
      check("rst_stall",    stall_cnt, 32'd0);
      cyc();
    end
    reset = 1'b0;
    #1;
    check("post_rst_data_gnt", {31'b0, data_gnt}, 32'd1);
    check("post_rst_inst_gnt", {31'b0, inst_gnt}, 32'd0);
    check("post_rst_stall",    stall_cnt, 32'd0);

    // 2: back-to-back fetches, one response per cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      inst_req   = (k < 4);
      inst_addr  = 32'hBFC0_0000 + 32'(4 * k);
      sram_rdata = (k > 0) ? 32'h2408_0000 + 32'(k) : 32'h0;
      #1;
      check("fetch_gnt", {31'b0, inst_gnt}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) check("fetch_addr", sram_addr, 32'hBFC0_0000 + 32'(4 * k));
      check("fetch_rdy", {31'b0, inst_rdy}, (k > 0) ? 32'd1 : 32'd0);
      check("fetch_rdata", inst_rdata, (k > 0) ? 32'h2408_0000 + 32'(k) : 32'h0);
      check("fetch_no_data_rdy", {31'b0, data_rdy}, 32'd0);
      cyc();
    end

    // 3: both held -> D,D,D,D,I repeating, 8 stalls in 10 cycles
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_1000;
    data_req  = 1'b1;
    data_addr = 32'h0000_2000;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("starve_inst_gnt", {31'b0, inst_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      check("starve_data_gnt", {31'b0, data_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      cyc();
    end
    #1;
    check("starve_stall_cnt", stall_cnt, 32'd8);

    // 4: partial store beats a pending fetch; response overlaps the next grant
    do_reset();
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_0200;
    data_req   = 1'b1;
    data_wen   = 4'b0011;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_data_gnt", {31'b0, data_gnt}, 32'd1);
    check("st_inst_gnt", {31'b0, inst_gnt}, 32'd0);
    check("st_sram_wen", {28'b0, sram_wen}, 32'h3);
    check("st_sram_addr", sram_addr, 32'h0000_0100);
    check("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    cyc();
    data_req   = 1'b0;
    data_wen   = 4'h0;
    sram_rdata = 32'h1234_5678;
    #1;
    check("st_data_rdy", {31'b0, data_rdy}, 32'd1);
    check("st_data_rdata", data_rdata, 32'h1234_5678);
    check("st_inst_gnt_overlap", {31'b0, inst_gnt}, 32'd1);
    check("st_fetch_wen", {28'b0, sram_wen}, 32'h0);
    check("st_fetch_addr", sram_addr, 32'h0000_0200);
    cyc();
    inst_req   = 1'b0;
    sram_rdata = 32'hCAFE_0001;
    #1;
    check("st_inst_rdy", {31'b0, inst_rdy}, 32'd1);
    check("st_inst_rdata", inst_rdata, 32'hCAFE_0001);
    check("st_data_rdy_low", {31'b0, data_rdy}, 32'd0);
    check("st_data_rdata_low", data_rdata, 32'h0);

    // 5: cancel drops an in-flight fetch and blocks new fetch grants
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0300;
    #1;
    check("cxl_gnt_before", {31'b0, inst_gnt}, 32'd1);
    cyc();
    cancel     = 1'b1;
    sram_rdata = 32'h5555_AAAA;
    #1;
    check("cxl_inst_rdy", {31'b0, inst_rdy}, 32'd0);
    check("cxl_inst_rdata", inst_rdata, 32'h0);
    check("cxl_inst_gnt", {31'b0, inst_gnt}, 32'd0);
    check("cxl_sram_en", {31'b0, sram_en}, 32'd0);
    cyc();
    #1;
    check("cxl_stall_cnt", stall_cnt, 32'd0);
    cancel   = 1'b0;
    inst_req = 1'b0;
    #1;
    check("cxl_no_replay", {31'b0, inst_rdy}, 32'd0);

    // 6: reset right after a fetch grant discards the response
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0400;
    data_req  = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    data_req = 1'b0;
    #1;
    check("rst6_inst_gnt", {31'b0, inst_gnt}, 32'd1);
    check("rst6_stall_pre", stall_cnt, 32'd4);
    cyc();
    reset = 1'b1;
    #1;
    check("rst6_rdy_n1", {31'b0, inst_rdy}, 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    check("rst6_rdy_n2", {31'b0, inst_rdy}, 32'd0);
    check("rst6_stall", stall_cnt, 32'd0);

    // streak must be cleared by reset: build it to 3, reset, then two data wins
    data_req = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rst6_streak_d0", {31'b0, data_gnt}, 32'd1);
    cyc();
    #1;
    check("rst6_streak_d1", {31'b0, data_gnt}, 32'd1);
    check("rst6_streak_i1", {31'b0, inst_gnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
